// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Purpose : Shared definitions for the multi-lane song editor.
//           - EDIT_MODE_DEFAULT : game-mode value in which editing is enabled.
//             The mode controller uses the same constant.
//           - edit_op_e         : the single edit operation chosen each cycle
//                                 by the priority decoder in song_editor_multi.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package song_pkg;

    localparam logic [2:0] EDIT_MODE_DEFAULT = 3'd2;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_CLR  = 3'd1,
        OP_BACK = 3'd2,
        OP_WR0  = 3'd3,
        OP_WR1  = 3'd4
    } edit_op_e;

endpackage : song_pkg

// File: rtl/song_editor_multi_lane.sv
// ---------------------------------------------------------------------------
// song_lane
// Purpose : Storage and cursor logic for one note lane.
//           The cursor starts at the top step (SONG_LEN-1) and moves down
//           on every write. Backspace moves it back up and restores the
//           initial content of the step it returns to.
// Ports   :
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : this lane is the selected lane this cycle
//   op         : decoded edit operation (OP_NONE when not editing)
//   init_bits  : reset/clear content of this lane (constant)
//   bits       : current lane content
//   cursor     : next step to be written
//   full       : set when the last step (0) was written and WRAP=0
// ---------------------------------------------------------------------------
module song_lane
    import song_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter bit WRAP     = 1'b0,
    localparam int PW      = $clog2(SONG_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  edit_op_e            op,
    input  logic [SONG_LEN-1:0] init_bits,
    output logic [SONG_LEN-1:0] bits,
    output logic [PW-1:0]       cursor,
    output logic                full
);

    localparam logic [PW-1:0] TOP = PW'(SONG_LEN - 1);

    logic [PW-1:0] cur_inc;
    logic [PW-1:0] cur_dec;

    assign cur_inc = cursor + 1'b1;
    assign cur_dec = cursor - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits   <= init_bits;
            cursor <= TOP;
            full   <= 1'b0;
        end else if (enable) begin
            case (op)
                OP_CLR: begin
                    bits   <= init_bits;
                    cursor <= TOP;
                    full   <= 1'b0;
                end
                OP_BACK: begin
                    // A full lane still has its cursor parked at 0, so undoing
                    // the last write only drops the flag and restores step 0.
                    if (full) begin
                        full    <= 1'b0;
                        bits[0] <= init_bits[0];
                    end else if (cursor != TOP) begin
                        cursor        <= cur_inc;
                        bits[cur_inc] <= init_bits[cur_inc];
                    end
                end
                OP_WR0, OP_WR1: begin
                    if (!full) begin
                        bits[cursor] <= (op == OP_WR1);
                        if (cursor != '0) begin
                            cursor <= cur_dec;
                        end else if (WRAP) begin
                            cursor <= TOP;
                        end else begin
                            full <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : song_lane

// File: rtl/song_editor_multi.sv
// ---------------------------------------------------------------------------
// song_editor_multi
// Purpose : Records a LANES x SONG_LEN binary note pattern from button
//           pulses. Holds the lane selector, the registered edit-mode flag
//           and the per-cycle edit-operation priority decoder; per-lane
//           storage lives in song_lane instances.
// Ports   :
//   clk, rst    : clock, asynchronous active-high reset
//   mode        : game mode; pulses act only when mode == EDIT_MODE
//   toggle_p    : pulse, select next lane (combinable with one edit)
//   note_p      : pulses, bit0 = write 0, bit1 = write 1 (2'b11 ignored)
//   back_p      : pulse, backspace on selected lane
//   clr_p       : pulse, clear selected lane
//   song        : flattened pattern, lane k at [k*SONG_LEN +: SONG_LEN]
//   lane_sel    : currently selected lane
//   position    : cursor of the selected lane
//   lane_full   : per-lane full flags
//   edit_active : registered (mode == EDIT_MODE)
// Pulse inputs are single-cycle strobes with no back-pressure: each one
// is consumed in the cycle it is high, or dropped outside edit mode.
// ---------------------------------------------------------------------------
module song_editor_multi
    import song_pkg::*;
#(
    parameter int                        LANES        = 2,
    parameter int                        SONG_LEN     = 32,
    parameter logic [2:0]                EDIT_MODE    = EDIT_MODE_DEFAULT,
    parameter bit                        WRAP         = 1'b0,
    parameter logic [LANES*SONG_LEN-1:0] INIT_PATTERN = {32'hAAAAAAAA, 32'hCCCCCCCC},
    localparam int                       LW           = (LANES > 2) ? $clog2(LANES) : 1,
    localparam int                       PW           = $clog2(SONG_LEN)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                mode,
    input  logic                      toggle_p,
    input  logic [1:0]                note_p,
    input  logic                      back_p,
    input  logic                      clr_p,
    output logic [LANES*SONG_LEN-1:0] song,
    output logic [LW-1:0]             lane_sel,
    output logic [PW-1:0]             position,
    output logic [LANES-1:0]          lane_full,
    output logic                      edit_active
);

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic          edit_en;
    edit_op_e      op;
    logic [PW-1:0] cur_arr [LANES];

    // Mode is sampled directly rather than through edit_active so a pulse
    // arriving in the first edit-mode cycle is not lost.
    assign edit_en = (mode == EDIT_MODE);

    // Priority decode: clear > backspace > note write.
    always_comb begin
        op = OP_NONE;
        if (edit_en) begin
            if (clr_p) begin
                op = OP_CLR;
            end else if (back_p) begin
                op = OP_BACK;
            end else if (note_p == 2'b01) begin
                op = OP_WR0;
            end else if (note_p == 2'b10) begin
                op = OP_WR1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_sel    <= '0;
            edit_active <= 1'b0;
        end else begin
            edit_active <= edit_en;
            if (edit_en && toggle_p) begin
                lane_sel <= (lane_sel == LAST_LANE) ? '0 : lane_sel + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        song_lane #(
            .SONG_LEN (SONG_LEN),
            .WRAP     (WRAP)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .enable    (lane_sel == LW'(k)),
            .op        (op),
            .init_bits (INIT_PATTERN[k*SONG_LEN +: SONG_LEN]),
            .bits      (song[k*SONG_LEN +: SONG_LEN]),
            .cursor    (cur_arr[k]),
            .full      (lane_full[k])
        );
    end

    always_comb begin
        position = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_sel == LW'(k)) begin
                position = cur_arr[k];
            end
        end
    end

endmodule : song_editor_multi
